// File: rtl/flag_register_pkg.sv
// Shared flag-bit indices, branch condition codes and the condition evaluator
// used by the flag register and its save stack.
package flag_register_pkg;

    localparam int FLAG_W = 4;
    localparam int FLAG_C = 0;
    localparam int FLAG_O = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 3;

    typedef enum logic [3:0] {
        COND_AL = 4'd0,
        COND_C  = 4'd1,
        COND_NC = 4'd2,
        COND_Z  = 4'd3,
        COND_NZ = 4'd4,
        COND_N  = 4'd5,
        COND_NN = 4'd6,
        COND_O  = 4'd7,
        COND_NO = 4'd8,
        COND_HI = 4'd9,
        COND_LS = 4'd10,
        COND_GE = 4'd11,
        COND_LT = 4'd12,
        COND_GT = 4'd13,
        COND_LE = 4'd14,
        COND_NV = 4'd15
    } cond_e;

    function automatic logic cond_eval(input logic [3:0] cond, input logic [FLAG_W-1:0] f);
        logic c, o, z, n;
        c = f[FLAG_C];
        o = f[FLAG_O];
        z = f[FLAG_Z];
        n = f[FLAG_N];
        case (cond_e'(cond))
            COND_AL: cond_eval = 1'b1;
            COND_C:  cond_eval = c;
            COND_NC: cond_eval = ~c;
            COND_Z:  cond_eval = z;
            COND_NZ: cond_eval = ~z;
            COND_N:  cond_eval = n;
            COND_NN: cond_eval = ~n;
            COND_O:  cond_eval = o;
            COND_NO: cond_eval = ~o;
            COND_HI: cond_eval = c & ~z;
            COND_LS: cond_eval = ~c | z;
            COND_GE: cond_eval = (n == o);
            COND_LT: cond_eval = (n != o);
            COND_GT: cond_eval = ~z & (n == o);
            COND_LE: cond_eval = z | (n != o);
            default: cond_eval = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/flag_register_stack.sv
// LIFO save stack for the flag word: push, pop and push+pop exchange, with
// full/empty status and a single-cycle error pulse on overflow or underflow.
module flag_stack
    import flag_register_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [FLAG_W-1:0] i_data,
    output logic [FLAG_W-1:0] o_top,
    output logic              o_pop_valid,
    output logic              o_empty,
    output logic              o_full,
    output logic              o_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CNT_W-1:0]  r_occ;
    logic [FLAG_W-1:0] r_mem [DEPTH];

    logic [CNT_W-1:0] w_occ_m1;
    logic [IDX_W-1:0] w_top_idx;
    logic [IDX_W-1:0] w_wr_idx;
    logic             w_empty;
    logic             w_full;
    logic             w_push_ok;
    logic             w_pop_ok;
    logic             w_xchg;

    assign w_occ_m1  = r_occ - CNT_W'(1);
    assign w_top_idx = w_occ_m1[IDX_W-1:0];
    assign w_empty   = (r_occ == '0);
    assign w_full    = (r_occ == CNT_W'(DEPTH));

    // Exchange overwrites the current top; a plain push writes one slot above it.
    assign w_push_ok = i_push & ~i_pop & ~w_full;
    assign w_pop_ok  = i_pop & ~i_push & ~w_empty;
    assign w_xchg    = i_push & i_pop & ~w_empty;
    assign w_wr_idx  = w_xchg ? w_top_idx : r_occ[IDX_W-1:0];

    assign o_top       = w_empty ? '0 : r_mem[w_top_idx];
    assign o_pop_valid = i_pop & ~w_empty;
    assign o_empty     = w_empty;
    assign o_full      = w_full;
    assign o_err       = (i_push & ~i_pop & w_full) | (i_pop & w_empty);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_occ <= '0;
        end else if (w_push_ok) begin
            r_occ <= r_occ + CNT_W'(1);
        end else if (w_pop_ok) begin
            r_occ <= w_occ_m1;
        end
    end

    // Contents are left alone by reset; only the occupancy defines what is valid.
    always_ff @(posedge clk) begin
        if (!reset && (w_push_ok || w_xchg)) begin
            r_mem[w_wr_idx] <= i_data;
        end
    end

endmodule

// File: rtl/flag_register.sv
// Architectural {N,Z,O,C} status register: merges set/clear and ALU updates,
// saves/restores through flag_stack and decodes the branch condition.
module flag_register
    import flag_register_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_we,
    input  logic [FLAG_W-1:0] alu_flags,
    input  logic [FLAG_W-1:0] alu_mask,
    input  logic              set_we,
    input  logic [FLAG_W-1:0] set_flags,
    input  logic              push,
    input  logic              pop,
    input  logic              err_clr,
    input  logic [3:0]        cond,
    output logic [FLAG_W-1:0] flags,
    output logic              cond_true,
    output logic              stack_empty,
    output logic              stack_full,
    output logic              stack_err
);

    logic [FLAG_W-1:0] r_flags;
    logic              r_stack_err;

    logic [FLAG_W-1:0] w_top;
    logic              w_pop_valid;
    logic              w_err_pulse;

    flag_stack #(
        .DEPTH (DEPTH)
    ) u_stack (
        .clk         (clk),
        .reset       (reset),
        .i_push      (push),
        .i_pop       (pop),
        .i_data      (r_flags),
        .o_top       (w_top),
        .o_pop_valid (w_pop_valid),
        .o_empty     (stack_empty),
        .o_full      (stack_full),
        .o_err       (w_err_pulse)
    );

    // A valid pop (including exchange) restores flags and drops any set/ALU write.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags <= '0;
        end else if (w_pop_valid) begin
            r_flags <= w_top;
        end else if (set_we) begin
            r_flags <= set_flags;
        end else if (alu_we) begin
            r_flags <= (alu_flags & alu_mask) | (r_flags & ~alu_mask);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stack_err <= 1'b0;
        end else if (w_err_pulse) begin
            r_stack_err <= 1'b1;
        end else if (err_clr) begin
            r_stack_err <= 1'b0;
        end
    end

    assign flags     = r_flags;
    assign stack_err = r_stack_err;
    assign cond_true = cond_eval(cond, r_flags);

endmodule
